// File: rtl/eq_pkg.sv
// Shared scan codes, prefix-FSM state codes and gain type for the equalizer dial controller.
package eq_pkg;

    localparam int unsigned NBANDS = 12;
    localparam int unsigned GAIN_W = 5;
    localparam int unsigned BAND_W = 4;

    typedef logic [GAIN_W-1:0] gain_t;

    localparam gain_t GAIN_MAX   = 5'd24;
    localparam gain_t GAIN_RESET = 5'd12;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    typedef logic [1:0] prefix_state_t;

    localparam prefix_state_t ST_IDLE    = 2'd0;
    localparam prefix_state_t ST_EXT     = 2'd1;
    localparam prefix_state_t ST_BRK     = 2'd2;
    localparam prefix_state_t ST_EXT_BRK = 2'd3;

endpackage

// File: rtl/ps2_arrow_decoder.sv
// PS/2 prefix decoder producing one-cycle arrow-key make pulses.
// TYPEMATIC_FILTER_EN: suppress typematic repeats until the matching break arrives.
module ps2_arrow_decoder
    import eq_pkg::*;
(
    input  logic       clk50,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic       left_c,
    output logic       right_c,
    output logic       up_c,
    output logic       down_c
);

    prefix_state_t state, state_nxt;
    logic [3:0]    arrow_c;
    logic [3:0]    make_c;
    logic [3:0]    act_c;

    // Key bit order: 0 left, 1 right, 2 up, 3 down.
    assign arrow_c = {scan_code == SC_DOWN, scan_code == SC_UP,
                      scan_code == SC_RIGHT, scan_code == SC_LEFT};

`ifdef TYPEMATIC_FILTER_EN
    logic [3:0] held, held_nxt;
    logic [3:0] brk_c;
`endif

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
`ifdef TYPEMATIC_FILTER_EN
            held  <= 4'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef TYPEMATIC_FILTER_EN
            held  <= held_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        make_c    = 4'b0;
`ifdef TYPEMATIC_FILTER_EN
        brk_c     = 4'b0;
`endif
        if (scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)      state_nxt = ST_EXT;
                    else if (scan_code == SC_BRK) state_nxt = ST_BRK;
                end
                ST_EXT: begin
                    if (scan_code == SC_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else begin
                        state_nxt = ST_IDLE;
                        make_c    = arrow_c;
                    end
                end
                ST_BRK: state_nxt = ST_IDLE;
                default: begin
                    state_nxt = ST_IDLE;
`ifdef TYPEMATIC_FILTER_EN
                    brk_c     = arrow_c;
`endif
                end
            endcase
        end
    end

    // A make acts only for a key not already held down.
`ifdef TYPEMATIC_FILTER_EN
    always_comb begin
        act_c    = make_c & ~held;
        held_nxt = (held | act_c) & ~brk_c;
    end
`else
    assign act_c = make_c;
`endif

    assign left_c  = act_c[0];
    assign right_c = act_c[1];
    assign up_c    = act_c[2];
    assign down_c  = act_c[3];

endmodule

// File: rtl/equalizer_dial_controller.sv
// Arrow-key band/gain editor with a shadow bank committed to the 12 output dials on frame_sync.
// TYPEMATIC_FILTER_EN (in ps2_arrow_decoder): one gain step per physical key press.
module equalizer_dial_controller
    import eq_pkg::*;
(
    input  logic        clk50,
    input  logic        reset,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    input  logic        frame_sync,
    output logic [4:0]  dial31,
    output logic [4:0]  dial72,
    output logic [4:0]  dial150,
    output logic [4:0]  dial250,
    output logic [4:0]  dial440,
    output logic [4:0]  dial630,
    output logic [4:0]  dial1000,
    output logic [4:0]  dial2500,
    output logic [4:0]  dial5000,
    output logic [4:0]  dial8000,
    output logic [4:0]  dial14000,
    output logic [4:0]  dial20000,
    output logic [3:0]  sel_band,
    output logic        pending
);

    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NBANDS - 1);

    logic              left_c, right_c, up_c, down_c;
    gain_t             dial_shadow [NBANDS];
    gain_t             dial_out    [NBANDS];
    gain_t             gain_cur_c, gain_nxt_c;
    logic              gain_chg_c;
    logic [BAND_W-1:0] sel_nxt_c;

    ps2_arrow_decoder u_decoder (
        .clk50      (clk50),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .left_c     (left_c),
        .right_c    (right_c),
        .up_c       (up_c),
        .down_c     (down_c)
    );

    // Band select wraps both ways; gain steps saturate and a saturated step is not a change.
    always_comb begin
        sel_nxt_c  = sel_band;
        gain_cur_c = dial_shadow[sel_band];
        gain_nxt_c = gain_cur_c;
        gain_chg_c = 1'b0;
        if (left_c) begin
            sel_nxt_c = (sel_band == '0) ? BAND_LAST : sel_band - BAND_W'(1);
        end else if (right_c) begin
            sel_nxt_c = (sel_band == BAND_LAST) ? '0 : sel_band + BAND_W'(1);
        end else if (up_c && gain_cur_c != GAIN_MAX) begin
            gain_nxt_c = gain_cur_c + GAIN_W'(1);
            gain_chg_c = 1'b1;
        end else if (down_c && gain_cur_c != '0) begin
            gain_nxt_c = gain_cur_c - GAIN_W'(1);
            gain_chg_c = 1'b1;
        end
    end

    // Outputs capture the pre-edit shadow, so an edit on a frame_sync edge waits one frame.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            sel_band <= '0;
            pending  <= 1'b0;
            for (int i = 0; i < NBANDS; i++) begin
                dial_shadow[i] <= GAIN_RESET;
                dial_out[i]    <= GAIN_RESET;
            end
        end else begin
            sel_band <= sel_nxt_c;
            pending  <= gain_chg_c | (pending & ~frame_sync);
            if (gain_chg_c) dial_shadow[sel_band] <= gain_nxt_c;
            if (frame_sync) dial_out <= dial_shadow;
        end
    end

    assign dial31    = dial_out[0];
    assign dial72    = dial_out[1];
    assign dial150   = dial_out[2];
    assign dial250   = dial_out[3];
    assign dial440   = dial_out[4];
    assign dial630   = dial_out[5];
    assign dial1000  = dial_out[6];
    assign dial2500  = dial_out[7];
    assign dial5000  = dial_out[8];
    assign dial8000  = dial_out[9];
    assign dial14000 = dial_out[10];
    assign dial20000 = dial_out[11];

endmodule

// File: tb/tb_equalizer_dial_controller.sv
// Self-checking bench for equalizer_dial_controller: directed scenarios plus random bytes vs a reference model.
module tb_equalizer_dial_controller;

    logic       clk50 = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_sync;
    logic [4:0] dial31, dial72, dial150, dial250, dial440, dial630;
    logic [4:0] dial1000, dial2500, dial5000, dial8000, dial14000, dial20000;
    logic [3:0] sel_band;
    logic       pending;
    logic [4:0] dut_d [12];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: gains as integers, prefix history as two flags, held keys by scan code.
    int m_shadow [12];
    int m_disp   [12];
    int m_sel;
    bit m_pend, m_ext, m_brk;
    bit m_held [256];

    always #10 clk50 = ~clk50;

    equalizer_dial_controller dut (
        .clk50      (clk50),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_sync (frame_sync),
        .dial31     (dial31),
        .dial72     (dial72),
        .dial150    (dial150),
        .dial250    (dial250),
        .dial440    (dial440),
        .dial630    (dial630),
        .dial1000   (dial1000),
        .dial2500   (dial2500),
        .dial5000   (dial5000),
        .dial8000   (dial8000),
        .dial14000  (dial14000),
        .dial20000  (dial20000),
        .sel_band   (sel_band),
        .pending    (pending)
    );

    assign dut_d[0]  = dial31;
    assign dut_d[1]  = dial72;
    assign dut_d[2]  = dial150;
    assign dut_d[3]  = dial250;
    assign dut_d[4]  = dial440;
    assign dut_d[5]  = dial630;
    assign dut_d[6]  = dial1000;
    assign dut_d[7]  = dial2500;
    assign dut_d[8]  = dial5000;
    assign dut_d[9]  = dial8000;
    assign dut_d[10] = dial14000;
    assign dut_d[11] = dial20000;

    task automatic model_reset();
        for (int i = 0; i < 12; i++) begin
            m_shadow[i] = 12;
            m_disp[i]   = 12;
        end
        for (int k = 0; k < 256; k++) m_held[k] = 1'b0;
        m_sel = 0; m_pend = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] b, input bit fs);
        int ev;
        bit changed;
        ev = -1;
        changed = 1'b0;
        if (fs) m_disp = m_shadow;
        if (v) begin
            if (m_ext && m_brk) begin
                m_held[b] = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
            end else if (m_brk) begin
                m_brk = 1'b0;
            end else if (m_ext) begin
                if (b == 8'hF0) m_brk = 1'b1;
                else begin
                    m_ext = 1'b0;
                    if (b == 8'h6B || b == 8'h74 || b == 8'h75 || b == 8'h72) ev = int'(b);
                end
            end else if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
        end
`ifdef TYPEMATIC_FILTER_EN
        if (ev >= 0) begin
            if (m_held[ev]) ev = -1;
            else m_held[ev] = 1'b1;
        end
`endif
        case (ev)
            'h6B: m_sel = (m_sel + 11) % 12;
            'h74: m_sel = (m_sel + 1) % 12;
            'h75: if (m_shadow[m_sel] < 24) begin m_shadow[m_sel]++; changed = 1'b1; end
            'h72: if (m_shadow[m_sel] > 0) begin m_shadow[m_sel]--; changed = 1'b1; end
            default: ;
        endcase
        m_pend = changed | (m_pend & !fs);
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit fs);
        @(negedge clk50);
        scan_valid = v; scan_code = b; frame_sync = fs;
        @(posedge clk50);
        model_edge(v, b, fs);
        #1;
        scan_valid = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic key(input logic [7:0] b);
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, b, 1'b0);
    endtask

    task automatic frame();
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk50);
        reset = 1'b1; scan_valid = 1'b0; frame_sync = 1'b0; scan_code = 8'h00;
        model_reset();
        @(negedge clk50);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (dut_d[i] !== 5'd12) begin
                n_bad++; $display("FAIL reset_dial%0d got %0d want 12", i, dut_d[i]);
            end
        end
        n_vec++;
        if (sel_band !== 4'd0 || pending !== 1'b0) begin
            n_bad++; $display("FAIL reset_sel_pend got sel=%0d pend=%0b want sel=0 pend=0", sel_band, pending);
        end
        // Partial prefix is discarded by reset: a lone 75 afterwards is not an "up".
        step(1'b1, 8'hE0, 1'b0);
        do_reset();
        step(1'b1, 8'h75, 1'b0);
        frame();
        n_vec++;
        if (dial31 !== 5'd12 || pending !== 1'b0) begin
            n_bad++; $display("FAIL reset_prefix got dial31=%0d pend=%0b want 12/0", dial31, pending);
        end
    endtask

    task automatic test_band_step();
        do_reset();
        key(8'h74); key(8'h74); key(8'h75);
        n_vec++;
        if (pending !== 1'b1) begin
            n_bad++; $display("FAIL step_pend_set got %0b want 1", pending);
        end
        key(8'h75);
        frame();
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (dut_d[i] !== ((i == 2) ? 5'd14 : 5'd12)) begin
                n_bad++; $display("FAIL step_dial%0d got %0d want %0d", i, dut_d[i], (i == 2) ? 14 : 12);
            end
        end
        n_vec++;
        if (sel_band !== 4'd2 || pending !== 1'b0) begin
            n_bad++; $display("FAIL step_sel_pend got sel=%0d pend=%0b want 2/0", sel_band, pending);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        key(8'h6B);
        n_vec++;
        if (sel_band !== 4'd11) begin
            n_bad++; $display("FAIL sat_wrap_left got %0d want 11", sel_band);
        end
        for (int i = 0; i < 14; i++) begin
            key(8'h75);
`ifdef TYPEMATIC_FILTER_EN
            step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h75, 1'b0);
`endif
        end
        frame();
        n_vec++;
        if (dial20000 !== 5'd24 || pending !== 1'b0) begin
            n_bad++; $display("FAIL sat_max got %0d pend=%0b want 24/0", dial20000, pending);
        end
        for (int i = 0; i < 30; i++) begin
            key(8'h72);
`ifdef TYPEMATIC_FILTER_EN
            step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h72, 1'b0);
`endif
        end
        frame();
        n_vec++;
        if (dial20000 !== 5'd0 || dial31 !== 5'd12) begin
            n_bad++; $display("FAIL sat_min got %0d dial31=%0d want 0/12", dial20000, dial31);
        end
        key(8'h74);
        n_vec++;
        if (sel_band !== 4'd0) begin
            n_bad++; $display("FAIL sat_wrap_right got %0d want 0", sel_band);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'h75, 1'b1);
        n_vec++;
        if (dial31 !== 5'd12 || pending !== 1'b1) begin
            n_bad++; $display("FAIL coinc_first got dial31=%0d pend=%0b want 12/1", dial31, pending);
        end
        frame();
        n_vec++;
        if (dial31 !== 5'd13 || pending !== 1'b0) begin
            n_bad++; $display("FAIL coinc_next got dial31=%0d pend=%0b want 13/0", dial31, pending);
        end
    endtask

    task automatic test_stray();
        do_reset();
        step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h75, 1'b0);
        n_vec++;
        if (pending !== 1'b0 || sel_band !== 4'd0) begin
            n_bad++; $display("FAIL stray_pre got pend=%0b sel=%0d want 0/0", pending, sel_band);
        end
        frame();
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (dut_d[i] !== 5'd12) begin
                n_bad++; $display("FAIL stray_dial%0d got %0d want 12", i, dut_d[i]);
            end
        end
    endtask

    task automatic test_typematic();
        logic [4:0] want;
`ifdef TYPEMATIC_FILTER_EN
        want = 5'd14;
`else
        want = 5'd18;
`endif
        do_reset();
        for (int i = 0; i < 5; i++) key(8'h75);
        step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h75, 1'b0);
        key(8'h75);
        frame();
        n_vec++;
        if (dial31 !== want) begin
            n_bad++; $display("FAIL typematic got %0d want %0d", dial31, want);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8];
        logic [7:0] b;
        bit v, fs;
        pool[0] = 8'hE0; pool[1] = 8'hE0; pool[2] = 8'hF0; pool[3] = 8'h6B;
        pool[4] = 8'h74; pool[5] = 8'h75; pool[6] = 8'h72; pool[7] = 8'h1C;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 9) < 7);
            b  = pool[$urandom_range(0, 7)];
            fs = ($urandom_range(0, 7) == 0);
            step(v, b, fs);
            for (int i = 0; i < 12; i++) begin
                n_vec++;
                if (dut_d[i] !== 5'(m_disp[i])) begin
                    n_bad++; $display("FAIL rand_dial%0d cyc %0d got %0d want %0d", i, c, dut_d[i], m_disp[i]);
                end
            end
            n_vec++;
            if (sel_band !== 4'(m_sel) || pending !== m_pend) begin
                n_bad++;
                $display("FAIL rand_sel_pend cyc %0d got sel=%0d pend=%0b want sel=%0d pend=%0b",
                         c, sel_band, pending, m_sel, m_pend);
            end
        end
    endtask

    initial begin
        reset = 1'b1; scan_valid = 1'b0; frame_sync = 1'b0; scan_code = 8'h00;
        model_reset();
        test_reset();
        test_band_step();
        test_saturation();
        test_coincident();
        test_stray();
        test_typematic();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/equalizer_dial_controller.md
Name: equalizer_dial_controller

Overview:
- Keyboard-side producer of the 12 per-band 5-bit gain dials consumed by the equalizer VGA band display and the audio gain path.
- Consumes PS/2 scan-code bytes from the existing keyboard receiver.
  - Left and right arrows select a band.
  - Up and down arrows step that band's gain in 1 dB steps over -12..+12 dB, encoded 0..24 with 12 = 0 dB.
- Edits go to a shadow bank. The shadow bank is copied to the output dials only on frame_sync (end of field), so a frame never shows a partial update.

Parameters:
- NBANDS, 12: number of bands; the port list is fixed at 12 dials.
- GAIN_MAX, 24: top code, +12 dB.
- GAIN_RESET, 12: reset/centre code, 0 dB.

Ports:
- clk50  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- scan_code  in  8  PS/2 byte from the keyboard receiver.
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle.
- frame_sync  in  1  one-cycle strobe at end of field (vcount wrap).
- dial31, dial72, dial150, dial250, dial440, dial630, dial1000, dial2500, dial5000, dial8000, dial14000, dial20000  out  5 each  displayed gain codes 0..24.
- sel_band  out  4  currently selected band, 0 = dial31 .. 11 = dial20000.
- pending  out  1  high while the shadow bank differs from the output dials.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE.
  - All shadow and output dials = GAIN_RESET.
  - sel_band = 0, pending = 0.
  - Reset mid-sequence discards any partial prefix.
- Prefix FSM (advances only on scan_valid):
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> IDLE, no action. Non-extended keys are ignored.
  - EXT: F0 -> EXT_BRK; 6B/74/75/72 -> make event, then IDLE; any other byte -> IDLE, no action.
  - BRK: any byte -> IDLE. Non-extended breaks are ignored.
  - EXT_BRK: any byte -> break event for that key, then IDLE.
- Make events, applied at the edge after the last byte's scan_valid (1-cycle latency):
  - E0 6B (left): sel_band = sel_band==0 ? 11 : sel_band-1 (wraps).
  - E0 74 (right): sel_band = sel_band==11 ? 0 : sel_band+1 (wraps).
  - E0 75 (up): shadow[sel_band] += 1; saturates at GAIN_MAX.
  - E0 72 (down): shadow[sel_band] -= 1; saturates at 0.
- Arithmetic: 5-bit unsigned; no wrap past 0 or 24. A saturated step is a no-op and does not set pending.
- Commit:
  - On a frame_sync cycle, all 12 outputs load the shadow values registered at that edge.
  - If frame_sync coincides with an event, outputs take the pre-event shadow; the event appears at the next frame_sync.
- pending:
  - Set at the edge applying any gain change.
  - Cleared at a frame_sync edge unless a gain change lands on that same edge.
- sel_band is not frame-gated; it updates immediately.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined:
  - Keep one held flag per arrow key. A make event acts only if that key's flag is clear, and then sets the flag.
  - The matching E0 F0 xx break clears the flag.
  - Reset clears all flags.
  - Typematic repeats of a held key are ignored: one step per press.
- Undefined: every make, including typematic repeats, acts.

Decomposition:
- Shared package eq_pkg holds:
  - scan-code constants (SC_EXT=E0, SC_BRK=F0, SC_LEFT=6B, SC_RIGHT=74, SC_UP=75, SC_DOWN=72);
  - the prefix FSM state enum;
  - gain_t (logic [4:0]);
  - GAIN_MAX and GAIN_RESET.
- Sub-module ps2_arrow_decoder:
  - contains the prefix FSM (and, under TYPEMATIC_FILTER_EN, the held flags);
  - emits one-cycle left/right/up/down make pulses.
- Top level holds sel_band, the shadow bank, the output bank and pending.

Test Plan:
- Reset, then frame_sync -> all dials = 12, sel_band = 0, pending = 0.
- E0 74, E0 74, E0 75, E0 75, then frame_sync -> sel_band = 2, dial150 = 14, other dials 12. pending goes high after the first up and low after frame_sync.
- Band 0, E0 6B -> sel_band = 11. Then 14 x (E0 75) and frame_sync -> dial20000 = 24, saturated. 30 x (E0 72) and frame_sync -> dial20000 = 0.
- E0 75 with its final byte coincident with frame_sync -> dial31 stays 12 that frame and becomes 13 at the next frame_sync.
- Stray bytes 1C, F0 1C, E0 12, E0 F0 75 -> no dial or sel_band change, pending = 0.
- TYPEMATIC_FILTER_EN defined: E0 75 x5 with no break, then E0 F0 75, E0 75, frame_sync -> dial31 = 14. Undefined, same stimulus -> dial31 = 18.
